// File: rtl/obi_mem_arbiter.sv
// N-port OBI round-robin request arbiter with in-order response routing.
// Address phase is locked to the selected port until the downstream grant arrives.
module obi_mem_arbiter #(
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned BE_W           = DATA_W / 8,
    localparam int unsigned ID_W           = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_PORTS-1:0]        req_i,
    output logic [NUM_PORTS-1:0]        gnt_o,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr_i,
    input  logic [NUM_PORTS-1:0]        we_i,
    input  logic [NUM_PORTS*BE_W-1:0]   be_i,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]        rvalid_o,
    output logic [NUM_PORTS*DATA_W-1:0] rdata_o,
    output logic                        mem_req_o,
    input  logic                        mem_gnt_i,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic                        mem_we_o,
    output logic [BE_W-1:0]             mem_be_o,
    output logic [DATA_W-1:0]           mem_wdata_o,
    input  logic                        mem_rvalid_i,
    input  logic [DATA_W-1:0]           mem_rdata_i,
    output logic [CNT_W-1:0]            outstanding_o,
    output logic                        protocol_err_o
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_next;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  locked_sel;
    logic [ID_W-1:0]  search_sel;
    logic             search_found;
    logic [ID_W-1:0]  sel;
    logic             full;
    logic             handshake;
    logic             pop;
    logic             rsp_err;

    logic [ID_W-1:0]  id_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [ID_W-1:0]  head;
    logic             prot_err;

    // Round-robin search starting at rr_ptr; falls back to rr_ptr when nobody requests.
    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] idx_id;
        search_sel   = rr_ptr;
        search_found = 1'b0;
        idx          = 0;
        idx_id       = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx    = (32'(rr_ptr) + i) % NUM_PORTS;
            idx_id = ID_W'(idx);
            if (!search_found && req_i[idx_id]) begin
                search_sel   = idx_id;
                search_found = 1'b1;
            end
        end
    end

    assign sel       = (state == ST_LOCKED) ? locked_sel : search_sel;
    assign full      = (count == CNT_W'(MAX_OUTSTANDING));
    assign mem_req_o = req_i[sel] & ~full;
    assign handshake = mem_req_o & mem_gnt_i;

    assign mem_addr_o  = addr_i[sel*ADDR_W +: ADDR_W];
    assign mem_we_o    = we_i[sel];
    assign mem_be_o    = be_i[sel*BE_W +: BE_W];
    assign mem_wdata_o = wdata_i[sel*DATA_W +: DATA_W];

    assign gnt_o = handshake ? (NUM_PORTS'(1) << sel) : '0;

    // A dropped request while locked simply falls back to IDLE without a grant.
    always_comb begin
        state_next = ST_IDLE;
        if (!handshake && mem_req_o) begin
            state_next = ST_LOCKED;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            locked_sel <= '0;
            rr_ptr     <= '0;
        end else begin
            state <= state_next;
            if (state_next == ST_LOCKED) begin
                locked_sel <= sel;
            end
            if (handshake) begin
                rr_ptr <= (sel == ID_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    assign pop     = mem_rvalid_i & (count != '0);
    assign rsp_err = mem_rvalid_i & (count == '0);
    assign head    = id_fifo[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (handshake) begin
            id_fifo[wr_ptr] <= sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            prot_err <= 1'b0;
        end else begin
            if (handshake) begin
                wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (handshake && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !handshake) begin
                count <= count - 1'b1;
            end
            if (rsp_err) begin
                prot_err <= 1'b1;
            end
        end
    end

    assign rvalid_o = pop ? (NUM_PORTS'(1) << head) : '0;

    always_comb begin
        rdata_o = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (pop && head == ID_W'(p)) begin
                rdata_o[p*DATA_W +: DATA_W] = mem_rdata_i;
            end
        end
    end

    assign outstanding_o  = count;
    assign protocol_err_o = prot_err;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Scenario bench for obi_mem_arbiter (2 ports, 4 outstanding): grants checked
// inline, expected responses queued at grant time and compared on rvalid.
module tb_obi_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [1:0]  req_i = '0;
    logic [1:0]  gnt_o;
    logic [63:0] addr_i = '0;
    logic [1:0]  we_i = '0;
    logic [7:0]  be_i = '0;
    logic [63:0] wdata_i = '0;
    logic [1:0]  rvalid_o;
    logic [63:0] rdata_o;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [2:0]  outstanding_o;
    logic        protocol_err_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    obi_mem_arbiter #(
        .NUM_PORTS(2),
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_i(req_i),
        .gnt_o(gnt_o),
        .addr_i(addr_i),
        .we_i(we_i),
        .be_i(be_i),
        .wdata_i(wdata_i),
        .rvalid_o(rvalid_o),
        .rdata_o(rdata_o),
        .mem_req_o(mem_req_o),
        .mem_gnt_i(mem_gnt_i),
        .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i),
        .outstanding_o(outstanding_o),
        .protocol_err_o(protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic quiet_inputs();
        req_i        = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        we_i         = '0;
        be_i         = '0;
    endtask

    task automatic do_reset();
        drive_step();
        quiet_inputs();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        sample();
        checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt_o); end
        checks++; if (rvalid_o !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b exp=00", rvalid_o); end
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req_o); end
        checks++; if (rdata_o !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding_o); end
        checks++; if (protocol_err_o !== 1'b0) begin failures++; $display("FAIL reset_prot_err got=%b exp=0", protocol_err_o); end
    endtask

    task automatic test_single();
        exp_t e;
        do_reset();
        drive_step();
        req_i          = 2'b10;
        addr_i[63:32]  = 32'h100;
        wdata_i[63:32] = 32'hDEADBEEF;
        be_i[7:4]      = 4'hF;
        we_i           = 2'b10;
        mem_gnt_i      = 1'b1;
        sample();
        checks++; if (gnt_o !== 2'b10) begin failures++; $display("FAIL single_gnt got=%b exp=10", gnt_o); end
        checks++; if (mem_addr_o !== 32'h100 || mem_we_o !== 1'b1 || mem_be_o !== 4'hF || mem_wdata_o !== 32'hDEADBEEF)
            begin failures++; $display("FAIL single_fields got=%h/%b/%h/%h exp=100/1/f/deadbeef", mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o); end
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL single_out0 got=%0d exp=0", outstanding_o); end
        sb.push_back('{port: 1, data: 32'h12345678});
        drive_step();
        req_i        = '0;
        we_i         = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h12345678;
        sample();
        checks++; if (outstanding_o !== 3'd1) begin failures++; $display("FAIL single_out1 got=%0d exp=1", outstanding_o); end
        e = sb.pop_front();
        checks++; if (rvalid_o !== 2'(1 << e.port)) begin failures++; $display("FAIL single_rvalid got=%b exp=%b", rvalid_o, 2'(1 << e.port)); end
        checks++; if (rdata_o[e.port*32 +: 32] !== e.data || rdata_o[(1-e.port)*32 +: 32] !== 32'h0)
            begin failures++; $display("FAIL single_rdata got=%h exp_port%0d=%h", rdata_o, e.port, e.data); end
        drive_step();
        mem_rvalid_i = 1'b0;
        sample();
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL single_out_end got=%0d exp=0", outstanding_o); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        do_reset();
        for (int k = 0; k <= 4; k++) begin
            drive_step();
            req_i        = (k < 4) ? 2'b11 : 2'b00;
            mem_gnt_i    = (k < 4);
            mem_rvalid_i = (k > 0);
            mem_rdata_i  = 32'hA0 + 32'(k) - 32'd1;
            sample();
            if (k < 4) begin
                checks++; if (gnt_o !== ((k % 2 == 0) ? 2'b01 : 2'b10))
                    begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, gnt_o, (k % 2 == 0) ? 2'b01 : 2'b10); end
                sb.push_back('{port: k % 2, data: 32'hA0 + 32'(k)});
            end
            checks++; if (outstanding_o !== ((k > 0) ? 3'd1 : 3'd0))
                begin failures++; $display("FAIL rr_out%0d got=%0d exp=%0d", k, outstanding_o, (k > 0) ? 1 : 0); end
            if (k > 0) begin
                e = sb.pop_front();
                checks++; if (rvalid_o !== 2'(1 << e.port)) begin failures++; $display("FAIL rr_rvalid%0d got=%b exp=%b", k, rvalid_o, 2'(1 << e.port)); end
                checks++; if (rdata_o[e.port*32 +: 32] !== e.data || rdata_o[(1-e.port)*32 +: 32] !== 32'h0)
                    begin failures++; $display("FAIL rr_rdata%0d got=%h exp_port%0d=%h", k, rdata_o, e.port, e.data); end
            end
        end
        drive_step();
        quiet_inputs();
    endtask

    task automatic test_lock();
        exp_t e;
        do_reset();
        addr_i[31:0]  = 32'h200;
        addr_i[63:32] = 32'h300;
        // first grant to port 0 moves rr_ptr to 1, so only the lock keeps port 0 selected
        drive_step();
        req_i     = 2'b01;
        mem_gnt_i = 1'b1;
        sample();
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL lock_pre_gnt got=%b exp=01", gnt_o); end
        sb.push_back('{port: 0, data: 32'h1111});
        for (int c = 0; c < 4; c++) begin
            drive_step();
            req_i     = (c == 0) ? 2'b01 : 2'b11;
            mem_gnt_i = (c == 3);
            sample();
            checks++; if (mem_addr_o !== 32'h200 || mem_req_o !== 1'b1)
                begin failures++; $display("FAIL lock_addr%0d got=%h req=%b exp=200 req=1", c, mem_addr_o, mem_req_o); end
            checks++; if (gnt_o !== ((c == 3) ? 2'b01 : 2'b00))
                begin failures++; $display("FAIL lock_gnt%0d got=%b exp=%b", c, gnt_o, (c == 3) ? 2'b01 : 2'b00); end
        end
        sb.push_back('{port: 0, data: 32'h2222});
        drive_step();
        req_i = 2'b10;
        sample();
        checks++; if (gnt_o !== 2'b10 || mem_addr_o !== 32'h300)
            begin failures++; $display("FAIL lock_next_gnt got=%b addr=%h exp=10 addr=300", gnt_o, mem_addr_o); end
        sb.push_back('{port: 1, data: 32'h3333});
        for (int r = 0; r < 3; r++) begin
            drive_step();
            req_i        = '0;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = (r == 0) ? 32'h1111 : (r == 1) ? 32'h2222 : 32'h3333;
            sample();
            e = sb.pop_front();
            checks++; if (rvalid_o !== 2'(1 << e.port) || rdata_o[e.port*32 +: 32] !== e.data)
                begin failures++; $display("FAIL lock_rsp%0d got=%b/%h exp_port%0d=%h", r, rvalid_o, rdata_o, e.port, e.data); end
        end
        drive_step();
        quiet_inputs();
    endtask

    task automatic test_full_fifo();
        exp_t e;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_step();
            req_i     = 2'b01;
            mem_gnt_i = 1'b1;
            sample();
            checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL full_gnt%0d got=%b exp=01", k, gnt_o); end
            sb.push_back('{port: 0, data: 32'hF00 + 32'(k)});
        end
        drive_step();
        sample();
        checks++; if (mem_req_o !== 1'b0 || gnt_o !== 2'b00 || outstanding_o !== 3'd4)
            begin failures++; $display("FAIL full_block got=req%b gnt%b out%0d exp=req0 gnt00 out4", mem_req_o, gnt_o, outstanding_o); end
        drive_step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hF00;
        sample();
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL full_pop_gate got=%b exp=0", mem_req_o); end
        e = sb.pop_front();
        checks++; if (rvalid_o !== 2'(1 << e.port) || rdata_o[e.port*32 +: 32] !== e.data)
            begin failures++; $display("FAIL full_pop got=%b/%h exp_port%0d=%h", rvalid_o, rdata_o, e.port, e.data); end
        drive_step();
        mem_rvalid_i = 1'b0;
        sample();
        checks++; if (mem_req_o !== 1'b1 || gnt_o !== 2'b01 || outstanding_o !== 3'd3)
            begin failures++; $display("FAIL full_resume got=req%b gnt%b out%0d exp=req1 gnt01 out3", mem_req_o, gnt_o, outstanding_o); end
        sb.push_back('{port: 0, data: 32'hF04});
        for (int r = 0; r < 4; r++) begin
            drive_step();
            req_i        = '0;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hF01 + 32'(r);
            sample();
            e = sb.pop_front();
            checks++; if (rvalid_o !== 2'(1 << e.port) || rdata_o[e.port*32 +: 32] !== e.data)
                begin failures++; $display("FAIL full_drain%0d got=%b/%h exp_port%0d=%h", r, rvalid_o, rdata_o, e.port, e.data); end
        end
        drive_step();
        quiet_inputs();
        sample();
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL full_empty got=%0d exp=0", outstanding_o); end
    endtask

    task automatic test_ordering();
        exp_t e;
        logic [31:0] vals [3];
        vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive_step();
            req_i     = 2'b11;
            mem_gnt_i = 1'b1;
            sample();
            checks++; if (gnt_o !== ((k == 1) ? 2'b10 : 2'b01))
                begin failures++; $display("FAIL ord_gnt%0d got=%b exp=%b", k, gnt_o, (k == 1) ? 2'b10 : 2'b01); end
            sb.push_back('{port: (k == 1) ? 1 : 0, data: vals[k]});
        end
        drive_step();
        req_i     = '0;
        mem_gnt_i = 1'b0;
        sample();
        checks++; if (outstanding_o !== 3'd3) begin failures++; $display("FAIL ord_out got=%0d exp=3", outstanding_o); end
        for (int r = 0; r < 3; r++) begin
            drive_step();
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = vals[r];
            sample();
            e = sb.pop_front();
            checks++; if (rvalid_o !== 2'(1 << e.port)) begin failures++; $display("FAIL ord_rvalid%0d got=%b exp=%b", r, rvalid_o, 2'(1 << e.port)); end
            checks++; if (rdata_o[e.port*32 +: 32] !== e.data || rdata_o[(1-e.port)*32 +: 32] !== 32'h0)
                begin failures++; $display("FAIL ord_rdata%0d got=%h exp_port%0d=%h", r, rdata_o, e.port, e.data); end
        end
        drive_step();
        quiet_inputs();
    endtask

    task automatic test_protocol_err();
        do_reset();
        drive_step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h55;
        sample();
        checks++; if (rvalid_o !== 2'b00 || rdata_o !== 64'h0)
            begin failures++; $display("FAIL perr_no_rvalid got=%b/%h exp=00/0", rvalid_o, rdata_o); end
        drive_step();
        mem_rvalid_i = 1'b0;
        sample();
        checks++; if (protocol_err_o !== 1'b1) begin failures++; $display("FAIL perr_set got=%b exp=1", protocol_err_o); end
        repeat (3) drive_step();
        sample();
        checks++; if (protocol_err_o !== 1'b1) begin failures++; $display("FAIL perr_sticky got=%b exp=1", protocol_err_o); end
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL perr_out got=%0d exp=0", outstanding_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive_step();
            req_i     = 2'b01;
            mem_gnt_i = 1'b1;
        end
        drive_step();
        mem_gnt_i = 1'b0;
        sample();
        checks++; if (outstanding_o !== 3'd2 || mem_req_o !== 1'b1)
            begin failures++; $display("FAIL mid_pre got=out%0d req%b exp=out2 req1", outstanding_o, mem_req_o); end
        #2;
        req_i = '0;
        rst_i = 1'b1;
        #1;
        checks++; if (outstanding_o !== 3'd0 || gnt_o !== 2'b00 || rvalid_o !== 2'b00 || mem_req_o !== 1'b0 || rdata_o !== 64'h0 || protocol_err_o !== 1'b0)
            begin failures++; $display("FAIL mid_async got=out%0d gnt%b rv%b req%b rd%h perr%b exp=all0", outstanding_o, gnt_o, rvalid_o, mem_req_o, rdata_o, protocol_err_o); end
        drive_step();
        rst_i = 1'b0;
        drive_step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h77;
        sample();
        checks++; if (rvalid_o !== 2'b00) begin failures++; $display("FAIL mid_stale_rvalid got=%b exp=00", rvalid_o); end
        drive_step();
        mem_rvalid_i = 1'b0;
        sample();
        checks++; if (protocol_err_o !== 1'b1) begin failures++; $display("FAIL mid_stale_perr got=%b exp=1", protocol_err_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_full_fifo();
        test_ordering();
        test_protocol_err();
        test_reset_mid();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
